// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline execution controller.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_RUN    = 3'b001,
    ST_STEP   = 3'b010,
    ST_DRAIN  = 3'b011,
    ST_HALTED = 3'b100
  } state_e;

  localparam int DRAIN_CNT_BITS = 4;

  function automatic logic is_step_state(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
  endfunction

  function automatic logic is_ready_state(input state_e s);
    return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HALTED);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_BITS = 32
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_inc,
  input  logic                i_clr,
  output logic [CNT_BITS-1:0] o_count
);

  logic [CNT_BITS-1:0] count_r;

  // Count register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_r <= '0;
    end else if (i_clr) begin
      count_r <= '0;
    end else if (i_inc && (count_r != {CNT_BITS{1'b1}})) begin
      count_r <= count_r + CNT_BITS'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign o_count = count_r;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer for the 5-stage pipeline: run/step/stop modes, HALT drain,
// step enable, per-latch flush strobes and executed-cycle counter.
module pipeline_exec_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_BITS     = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_halt_mem,
  input  logic                i_branch_taken,
  output logic                o_step,
  output logic                o_flush_ifid,
  output logic                o_flush_idex,
  output logic                o_flush_exmem,
  output logic                o_flush_memwb,
  output logic [2:0]          o_state,
  output logic                o_halted,
  output logic                o_cmd_err,
  output logic [CNT_BITS-1:0] o_cycle_count
);

  localparam logic [DRAIN_CNT_BITS-1:0] DRAIN_LOAD = DRAIN_CNT_BITS'(DRAIN_CYCLES);

  state_e                    state_r, state_nxt_s;
  logic [DRAIN_CNT_BITS-1:0] drain_cnt_r, drain_cnt_nxt_s;
  logic                      cmd_err_r, cmd_err_nxt_s;
  logic                      clear_pend_r, clear_nxt_s;
  logic                      step_s, ready_s, cmd_acc_s, branch_flush_s;
  cmd_e                      cmd_s;

  assign cmd_s     = cmd_e'(i_cmd);
  assign step_s    = is_step_state(state_r);
  assign ready_s   = is_ready_state(state_r);
  assign cmd_acc_s = i_cmd_valid & ready_s;

  // Next-state, drain count and command-error decode.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    cmd_err_nxt_s   = 1'b0;
    clear_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_acc_s) begin
          case (cmd_s)
            CMD_RUN:   state_nxt_s = ST_RUN;
            CMD_STEP:  state_nxt_s = ST_STEP;
            CMD_STOP:  state_nxt_s = ST_IDLE;
            CMD_CLEAR: clear_nxt_s = 1'b1;
            default:   state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A HALT reaching MEM outranks any command offered in the same cycle.
        if (i_halt_mem) begin
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = DRAIN_LOAD;
        end else if (cmd_acc_s) begin
          case (cmd_s)
            CMD_STOP:  state_nxt_s = ST_IDLE;
            CMD_CLEAR: begin
              state_nxt_s = ST_IDLE;
              clear_nxt_s = 1'b1;
            end
            default:   cmd_err_nxt_s = 1'b1;
          endcase
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STEP: begin
        if (i_halt_mem) begin
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = DRAIN_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        drain_cnt_nxt_s = drain_cnt_r - DRAIN_CNT_BITS'(1);
        if (drain_cnt_r <= DRAIN_CNT_BITS'(1)) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        if (cmd_acc_s && (cmd_s == CMD_CLEAR)) begin
          state_nxt_s = ST_IDLE;
          clear_nxt_s = 1'b1;
        end else if (cmd_acc_s) begin
          cmd_err_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        drain_cnt_nxt_s = '0;
      end
    endcase
  end

  // State, drain counter and registered strobes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r      <= ST_IDLE;
      drain_cnt_r  <= '0;
      cmd_err_r    <= 1'b0;
      clear_pend_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      drain_cnt_r  <= drain_cnt_nxt_s;
      cmd_err_r    <= cmd_err_nxt_s;
      clear_pend_r <= clear_nxt_s;
    end
  end

  // Counter clears on the accepting edge so the CLEAR cycle already reads zero.
  sat_counter #(.CNT_BITS(CNT_BITS)) u_cycle_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (step_s),
    .i_clr     (clear_nxt_s),
    .o_count   (o_cycle_count)
  );

  assign branch_flush_s = step_s & i_branch_taken;
  assign o_flush_ifid   = branch_flush_s | clear_pend_r;
  assign o_flush_idex   = branch_flush_s | clear_pend_r;
  assign o_flush_exmem  = branch_flush_s | clear_pend_r;
  assign o_flush_memwb  = clear_pend_r;

  assign o_step      = step_s;
  assign o_cmd_ready = ready_s;
  assign o_state     = state_r;
  assign o_halted    = (state_r == ST_HALTED);
  assign o_cmd_err   = cmd_err_r;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Scoreboard bench for pipeline_exec_ctrl: expected per-cycle outputs are queued as
// stimulus is driven and compared on the falling edge; a CNT_BITS=4 copy checks saturation.
module tb_pipeline_exec_ctrl;
  import mips_ctrl_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic        i_halt_mem;
  logic        i_branch_taken;

  logic        o_cmd_ready, o_step, o_flush_ifid, o_flush_idex, o_flush_exmem, o_flush_memwb;
  logic [2:0]  o_state;
  logic        o_halted, o_cmd_err;
  logic [31:0] o_cycle_count;

  logic        d4_cmd_ready, d4_step, d4_fl_ifid, d4_fl_idex, d4_fl_exmem, d4_fl_memwb;
  logic [2:0]  d4_state;
  logic        d4_halted, d4_cmd_err;
  logic [3:0]  d4_cycle_count;

  always #5 i_clk = ~i_clk;

  pipeline_exec_ctrl #(.CNT_BITS(32), .DRAIN_CYCLES(2)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt_mem(i_halt_mem), .i_branch_taken(i_branch_taken),
    .o_step(o_step), .o_flush_ifid(o_flush_ifid), .o_flush_idex(o_flush_idex),
    .o_flush_exmem(o_flush_exmem), .o_flush_memwb(o_flush_memwb), .o_state(o_state),
    .o_halted(o_halted), .o_cmd_err(o_cmd_err), .o_cycle_count(o_cycle_count)
  );

  pipeline_exec_ctrl #(.CNT_BITS(4), .DRAIN_CYCLES(2)) dut4 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(d4_cmd_ready), .i_halt_mem(i_halt_mem), .i_branch_taken(i_branch_taken),
    .o_step(d4_step), .o_flush_ifid(d4_fl_ifid), .o_flush_idex(d4_fl_idex),
    .o_flush_exmem(d4_fl_exmem), .o_flush_memwb(d4_fl_memwb), .o_state(d4_state),
    .o_halted(d4_halted), .o_cmd_err(d4_cmd_err), .o_cycle_count(d4_cycle_count)
  );

  typedef struct {
    int          cyc;
    logic [10:0] ctl;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [10:0] obs_ctl_s, obs4_ctl_s;

  assign obs_ctl_s  = {o_step, o_flush_ifid, o_flush_idex, o_flush_exmem, o_flush_memwb,
                       o_state, o_halted, o_cmd_err, o_cmd_ready};
  assign obs4_ctl_s = {d4_step, d4_fl_ifid, d4_fl_idex, d4_fl_exmem, d4_fl_memwb,
                       d4_state, d4_halted, d4_cmd_err, d4_cmd_ready};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ctl layout: {step, flush ifid/idex/exmem/memwb, state, halted, cmd_err, cmd_ready}
  task automatic push_exp(input string tag, input state_e st, input logic step,
                          input logic [3:0] fl, input logic err, input logic [31:0] cnt);
    exp_t e;
    logic rdy;
    rdy    = (st == ST_IDLE) || (st == ST_RUN) || (st == ST_HALTED);
    e.cyc  = cyc;
    e.ctl  = {step, fl, st, (st == ST_HALTED), err, rdy};
    e.cnt  = cnt;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    i_cmd_valid    = 1'b0;
    i_cmd          = 2'b00;
    i_halt_mem     = 1'b0;
    i_branch_taken = 1'b0;
  endtask

  task automatic send(input cmd_e c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
  endtask

  always @(negedge i_clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        check_eq({sb_q[i].tag, "_ctl"}, 32'(obs_ctl_s), 32'(sb_q[i].ctl));
        check_eq({sb_q[i].tag, "_cnt"}, o_cycle_count, sb_q[i].cnt);
        check_eq({sb_q[i].tag, "_ctl4"}, 32'(obs4_ctl_s), 32'(sb_q[i].ctl));
        check_eq({sb_q[i].tag, "_cnt4"}, 32'(d4_cycle_count),
                 (sb_q[i].cnt > 32'd15) ? 32'd15 : sb_q[i].cnt);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    i_reset_n      = 1'b0;
    i_cmd_valid    = 1'b0;
    i_cmd          = 2'b00;
    i_halt_mem     = 1'b0;
    i_branch_taken = 1'b0;

    tick();  // 1: in reset
    push_exp("reset", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'd0);
    tick();  // 2
    i_reset_n = 1'b1;
    push_exp("idle", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'd0);
    send(CMD_RUN);
    for (int c = 3; c <= 10; c++) begin
      tick();
      if (cyc == 5) begin
        i_branch_taken = 1'b1;
        push_exp("run_branch", ST_RUN, 1'b1, 4'b1110, 1'b0, 32'(cyc - 3));
      end else begin
        push_exp("run", ST_RUN, 1'b1, 4'b0000, (cyc == 8), 32'(cyc - 3));
      end
      if (cyc == 7) send(CMD_RUN);
      if (cyc == 10) send(CMD_STOP);
    end
    tick();  // 11
    i_branch_taken = 1'b1;
    push_exp("stop_nobranch", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'd8);
    tick();  // 12
    push_exp("idle_hold", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'd8);
    send(CMD_CLEAR);
    tick();  // 13
    push_exp("clear_idle", ST_IDLE, 1'b0, 4'b1111, 1'b0, 32'd0);
    tick();  // 14
    push_exp("post_clear", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'd0);
    send(CMD_STEP);
    for (int k = 0; k < 3; k++) begin
      tick();  // 15, 17, 19
      push_exp("step", ST_STEP, 1'b1, 4'b0000, 1'b0, 32'(k));
      send(CMD_STEP);  // offered while not ready: must be ignored
      tick();  // 16, 18, 20
      push_exp("step_done", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'(k + 1));
      if (k < 2) send(CMD_STEP);
    end
    send(CMD_RUN);
    tick();  // 21
    push_exp("run2", ST_RUN, 1'b1, 4'b0000, 1'b0, 32'd3);
    tick();  // 22
    push_exp("run2", ST_RUN, 1'b1, 4'b0000, 1'b0, 32'd4);
    tick();  // 23: halt outranks STOP
    push_exp("run_halt", ST_RUN, 1'b1, 4'b0000, 1'b0, 32'd5);
    i_halt_mem = 1'b1;
    send(CMD_STOP);
    tick();  // 24
    push_exp("drain1", ST_DRAIN, 1'b1, 4'b0000, 1'b0, 32'd6);
    tick();  // 25
    i_branch_taken = 1'b1;
    push_exp("drain2_branch", ST_DRAIN, 1'b1, 4'b1110, 1'b0, 32'd7);
    tick();  // 26
    i_branch_taken = 1'b1;
    push_exp("halted", ST_HALTED, 1'b0, 4'b0000, 1'b0, 32'd8);
    send(CMD_RUN);
    tick();  // 27
    push_exp("halted_run_err", ST_HALTED, 1'b0, 4'b0000, 1'b1, 32'd8);
    tick();  // 28
    push_exp("halted_err_off", ST_HALTED, 1'b0, 4'b0000, 1'b0, 32'd8);
    send(CMD_STOP);
    tick();  // 29
    push_exp("halted_stop_err", ST_HALTED, 1'b0, 4'b0000, 1'b1, 32'd8);
    send(CMD_CLEAR);
    tick();  // 30
    push_exp("halted_clear", ST_IDLE, 1'b0, 4'b1111, 1'b0, 32'd0);
    tick();  // 31
    push_exp("after_clear", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'd0);
    send(CMD_RUN);
    tick();  // 32
    push_exp("run3", ST_RUN, 1'b1, 4'b0000, 1'b0, 32'd0);
    i_halt_mem = 1'b1;
    tick();  // 33
    push_exp("drain_pre_rst", ST_DRAIN, 1'b1, 4'b0000, 1'b0, 32'd1);
    tick();  // 34: async reset mid-DRAIN
    i_reset_n = 1'b0;
    push_exp("rst_mid_drain", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'd0);
    tick();  // 35
    push_exp("rst_hold", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'd0);
    i_reset_n = 1'b1;
    tick();  // 36
    push_exp("rst_release", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'd0);
    send(CMD_RUN);
    for (int c = 37; c <= 56; c++) begin
      tick();
      if (cyc == 37 || cyc == 51 || cyc == 52 || cyc == 53 || cyc == 56)
        push_exp("run_sat", ST_RUN, 1'b1, 4'b0000, 1'b0, 32'(cyc - 37));
      if (cyc == 56) send(CMD_STOP);
    end
    tick();  // 57
    push_exp("sat_stop", ST_IDLE, 1'b0, 4'b0000, 1'b0, 32'd20);
    tick();

    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
